prescaled_compare_timer: RTL

Next-generation general-purpose timer for the custom core peripherals. It provides a WIDTH-bit up-counter driven by a programmable prescaler and a programmable compare value, in periodic or one-shot mode. It outputs a single-cycle tick on each match and a sticky interrupt flag. It sits beside simple_timer and supersedes it wherever a configurable period is needed.

---
 rtl/prescaled_compare_timer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/prescaled_compare_timer.sv
// Prescaled up-counter timer with compare match, periodic/one-shot modes and a sticky irq.
// Define PRESCALED_COMPARE_TIMER_CAPTURE_EN to build the edge-triggered capture register.
module prescaled_compare_timer #(
    parameter int WIDTH       = 8,
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic                   mode_i,
    input  logic                   load_i,
    input  logic [WIDTH-1:0]       cmp_i,
    input  logic [PRESC_WIDTH-1:0] prescale_i,
    input  logic                   irq_clr_i,
    input  logic                   capture_i,
    output logic                   tick_o,
    output logic                   irq_o,
    output logic                   running_o,
    output logic [WIDTH-1:0]       q_o,
    output logic [WIDTH-1:0]       cap_o,
    output logic                   cap_valid_o
);

    logic [WIDTH-1:0]       cmp_reg;
    logic [WIDTH-1:0]       count;
    logic [PRESC_WIDTH-1:0] psc_reg;
    logic [PRESC_WIDTH-1:0] psc_cnt;
    logic                   done;
    logic                   tick;
    logic                   irq;
    logic                   running;
    logic                   step;
    logic                   match;

    assign running = en_i & ~done;
    assign step    = running & (psc_cnt == psc_reg);
    assign match   = step & (count == cmp_reg);

    // A load restarts the period and suppresses any step in that same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmp_reg <= '1;
            psc_reg <= '0;
            psc_cnt <= '0;
            count   <= '0;
            done    <= 1'b0;
            tick    <= 1'b0;
        end else if (load_i) begin
            cmp_reg <= cmp_i;
            psc_reg <= prescale_i;
            psc_cnt <= '0;
            count   <= '0;
            done    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (running) begin
                if (psc_cnt == psc_reg) begin
                    psc_cnt <= '0;
                end else begin
                    psc_cnt <= psc_cnt + 1'b1;
                end
            end
            if (step) begin
                if (match) begin
                    count <= '0;
                    tick  <= 1'b1;
                    if (mode_i) begin
                        done <= 1'b1;
                    end
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    // Setting on a match outranks a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq <= 1'b0;
        end else if (match && !load_i) begin
            irq <= 1'b1;
        end else if (irq_clr_i) begin
            irq <= 1'b0;
        end
    end

    assign tick_o    = tick;
    assign irq_o     = irq;
    assign running_o = running;
    assign q_o       = count;

`ifdef PRESCALED_COMPARE_TIMER_CAPTURE_EN
    logic             capture_prev;
    logic [WIDTH-1:0] cap_reg;
    logic             cap_valid;

    // Rising-edge capture, independent of enable and untouched by load.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            capture_prev <= 1'b0;
            cap_reg      <= '0;
            cap_valid    <= 1'b0;
        end else begin
            capture_prev <= capture_i;
            cap_valid    <= 1'b0;
            if (capture_i && !capture_prev) begin
                cap_reg   <= count;
                cap_valid <= 1'b1;
            end
        end
    end

    assign cap_o       = cap_reg;
    assign cap_valid_o = cap_valid;
`else
    logic unused_capture;
    assign unused_capture = capture_i;
    assign cap_o          = '0;
    assign cap_valid_o    = 1'b0;
`endif

endmodule
